// File: rtl/spu_mem_pkg.sv
// Shared constants and types for the MEM-stage local-store consumer.
package spu_mem_pkg;

  localparam int DATA_W   = 128;
  localparam int REG_W    = 7;
  localparam int LS_DEPTH = 2048;
  localparam int ADDR_W   = 11;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } ls_state_t;

  typedef struct packed {
    logic              memToReg;
    logic              regWriteEnable;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] loadData;
    logic [REG_W-1:0]  registerRT;
  } wb_bundle_t;

endpackage

// File: rtl/ls_sram.sv
// Single-port local store: synchronous write, asynchronous read of the addressed quadword.
module ls_sram
  import spu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [LS_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_ls.sv
// Dual-issue MEM stage: serializes both pipes' accesses onto one local-store port
// and registers the writeback bundle for each pipe.
module mem_stage_ls
  import spu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              memToReg_MEM1,
  input  logic              memToReg_MEM2,
  input  logic              regWriteEnable_MEM1,
  input  logic              regWriteEnable_MEM2,
  input  logic              memRead_MEM1,
  input  logic              memRead_MEM2,
  input  logic              memWrite_MEM1,
  input  logic              memWrite_MEM2,
  input  logic [DATA_W-1:0] result_MEM1,
  input  logic [DATA_W-1:0] result_MEM2,
  input  logic [DATA_W-1:0] readDataRC_MEM1,
  input  logic [DATA_W-1:0] readDataRC_MEM2,
  input  logic [REG_W-1:0]  registerRT_MEM1,
  input  logic [REG_W-1:0]  registerRT_MEM2,
  output logic              stall,
  output logic              memToReg_WB1,
  output logic              memToReg_WB2,
  output logic              regWriteEnable_WB1,
  output logic              regWriteEnable_WB2,
  output logic [DATA_W-1:0] result_WB1,
  output logic [DATA_W-1:0] result_WB2,
  output logic [DATA_W-1:0] loadData_WB1,
  output logic [DATA_W-1:0] loadData_WB2,
  output logic [REG_W-1:0]  registerRT_WB1,
  output logic [REG_W-1:0]  registerRT_WB2
);

  ls_state_t         state_q;
  wb_bundle_t        wb1_q, wb2_q, buf_q;
  wb_bundle_t        live1, live2;
  logic              op1, op2, ld1, ld2, conflict, sel2, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;

  // A store flag wins over a load flag on the same pipe.
  assign op1      = memRead_MEM1 | memWrite_MEM1;
  assign op2      = memRead_MEM2 | memWrite_MEM2;
  assign ld1      = memRead_MEM1 & ~memWrite_MEM1;
  assign ld2      = memRead_MEM2 & ~memWrite_MEM2;
  assign conflict = op1 & op2;

  // Upstream holds its EX/MEM register while stall is high; the held bundle
  // is consumed in SECOND, where stall drops so the next bundle can advance.
  assign stall = reset & (state_q == IDLE) & conflict;

  // Pipe2 owns the port in SECOND, or in IDLE whenever pipe1 has no access.
  assign sel2       = (state_q == SECOND) | ~op1;
  assign sram_addr  = sel2 ? result_MEM2[ADDR_W+3:4] : result_MEM1[ADDR_W+3:4];
  assign sram_wdata = sel2 ? readDataRC_MEM2 : readDataRC_MEM1;
  assign sram_we    = reset & (sel2 ? memWrite_MEM2 : memWrite_MEM1);

  ls_sram u_ls_sram (
    .clk   (clk),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

  always_comb begin
    live1 = '{memToReg:       memToReg_MEM1,
              regWriteEnable: regWriteEnable_MEM1,
              result:         result_MEM1,
              loadData:       ld1 ? sram_rdata : '0,
              registerRT:     registerRT_MEM1};
    live2 = '{memToReg:       memToReg_MEM2,
              regWriteEnable: regWriteEnable_MEM2,
              result:         result_MEM2,
              loadData:       ld2 ? sram_rdata : '0,
              registerRT:     registerRT_MEM2};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wb1_q   <= '0;
      wb2_q   <= '0;
      buf_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (conflict) begin
            buf_q   <= live1;
            wb1_q   <= '0;
            wb2_q   <= '0;
            state_q <= SECOND;
          end else begin
            wb1_q <= live1;
            wb2_q <= live2;
          end
        end
        SECOND: begin
          wb1_q   <= buf_q;
          wb2_q   <= live2;
          buf_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign memToReg_WB1       = wb1_q.memToReg;
  assign memToReg_WB2       = wb2_q.memToReg;
  assign regWriteEnable_WB1 = wb1_q.regWriteEnable;
  assign regWriteEnable_WB2 = wb2_q.regWriteEnable;
  assign result_WB1         = wb1_q.result;
  assign result_WB2         = wb2_q.result;
  assign loadData_WB1       = wb1_q.loadData;
  assign loadData_WB2       = wb2_q.loadData;
  assign registerRT_WB1     = wb1_q.registerRT;
  assign registerRT_WB2     = wb2_q.registerRT;

endmodule

// File: tb/tb_mem_stage_ls.sv
// Randomized bench for mem_stage_ls against a sequential program-order memory model.
module tb_mem_stage_ls;
  import spu_mem_pkg::*;

  typedef struct {
    logic              mr, mw, m2r, rwe;
    logic [DATA_W-1:0] res, rc;
    logic [REG_W-1:0]  rt;
  } pipe_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic memToReg_MEM1, memToReg_MEM2, regWriteEnable_MEM1, regWriteEnable_MEM2;
  logic memRead_MEM1, memRead_MEM2, memWrite_MEM1, memWrite_MEM2;
  logic [DATA_W-1:0] result_MEM1, result_MEM2, readDataRC_MEM1, readDataRC_MEM2;
  logic [REG_W-1:0]  registerRT_MEM1, registerRT_MEM2;
  logic stall, memToReg_WB1, memToReg_WB2, regWriteEnable_WB1, regWriteEnable_WB2;
  logic [DATA_W-1:0] result_WB1, result_WB2, loadData_WB1, loadData_WB2;
  logic [REG_W-1:0]  registerRT_WB1, registerRT_WB2;

  mem_stage_ls dut (
    .clk(clk), .reset(reset),
    .memToReg_MEM1(memToReg_MEM1), .memToReg_MEM2(memToReg_MEM2),
    .regWriteEnable_MEM1(regWriteEnable_MEM1), .regWriteEnable_MEM2(regWriteEnable_MEM2),
    .memRead_MEM1(memRead_MEM1), .memRead_MEM2(memRead_MEM2),
    .memWrite_MEM1(memWrite_MEM1), .memWrite_MEM2(memWrite_MEM2),
    .result_MEM1(result_MEM1), .result_MEM2(result_MEM2),
    .readDataRC_MEM1(readDataRC_MEM1), .readDataRC_MEM2(readDataRC_MEM2),
    .registerRT_MEM1(registerRT_MEM1), .registerRT_MEM2(registerRT_MEM2),
    .stall(stall),
    .memToReg_WB1(memToReg_WB1), .memToReg_WB2(memToReg_WB2),
    .regWriteEnable_WB1(regWriteEnable_WB1), .regWriteEnable_WB2(regWriteEnable_WB2),
    .result_WB1(result_WB1), .result_WB2(result_WB2),
    .loadData_WB1(loadData_WB1), .loadData_WB2(loadData_WB2),
    .registerRT_WB1(registerRT_WB1), .registerRT_WB2(registerRT_WB2)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [DATA_W-1:0] ref_mem [int];
  logic [DATA_W-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  string wb_names [10] = '{"m2r1", "rwe1", "res1", "ld1", "rt1",
                           "m2r2", "rwe2", "res2", "ld2", "rt2"};

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pipe_t mk(input logic mr, input logic mw, input logic [DATA_W-1:0] res,
                               input logic [DATA_W-1:0] rc, input logic [REG_W-1:0] rt,
                               input logic rwe, input logic m2r);
    pipe_t p;
    p.mr = mr; p.mw = mw; p.res = res; p.rc = rc; p.rt = rt; p.rwe = rwe; p.m2r = m2r;
    return p;
  endfunction

  function automatic pipe_t nop();
    return mk(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endfunction

  function automatic bit has_op(input pipe_t p);
    return p.mr || p.mw;
  endfunction

  // Program-order model: one access, returns what a load would see.
  function automatic logic [DATA_W-1:0] model_access(input pipe_t p);
    int idx;
    idx = int'((p.res / 16) % LS_DEPTH);
    if (p.mw) begin
      ref_mem[idx] = p.rc;
      return '0;
    end
    if (p.mr) return ref_mem.exists(idx) ? ref_mem[idx] : '0;
    return '0;
  endfunction

  // Driver
  task automatic drive(input pipe_t p1, input pipe_t p2);
    memRead_MEM1 = p1.mr; memWrite_MEM1 = p1.mw; memToReg_MEM1 = p1.m2r;
    regWriteEnable_MEM1 = p1.rwe; result_MEM1 = p1.res; readDataRC_MEM1 = p1.rc;
    registerRT_MEM1 = p1.rt;
    memRead_MEM2 = p2.mr; memWrite_MEM2 = p2.mw; memToReg_MEM2 = p2.m2r;
    regWriteEnable_MEM2 = p2.rwe; result_MEM2 = p2.res; readDataRC_MEM2 = p2.rc;
    registerRT_MEM2 = p2.rt;
  endtask

  task automatic compare_wb(input string tag);
    logic [DATA_W-1:0] obs [10];
    obs = '{DATA_W'(memToReg_WB1), DATA_W'(regWriteEnable_WB1), result_WB1, loadData_WB1,
            DATA_W'(registerRT_WB1), DATA_W'(memToReg_WB2), DATA_W'(regWriteEnable_WB2),
            result_WB2, loadData_WB2, DATA_W'(registerRT_WB2)};
    for (int i = 0; i < 10; i++)
      check($sformatf("%s.%s", tag, wb_names[i]), obs[i], exp_q.pop_front());
  endtask

  task automatic push_zero_wb();
    for (int i = 0; i < 10; i++) exp_q.push_back('0);
  endtask

  task automatic push_wb(input pipe_t p, input logic [DATA_W-1:0] ld);
    exp_q.push_back(DATA_W'(p.m2r));
    exp_q.push_back(DATA_W'(p.rwe));
    exp_q.push_back(p.res);
    exp_q.push_back(ld);
    exp_q.push_back(DATA_W'(p.rt));
  endtask

  // Issue one bundle and check it through to writeback (1 or 2 cycles).
  task automatic issue(input string tag, input pipe_t p1, input pipe_t p2);
    logic [DATA_W-1:0] l1, l2;
    bit conflict;
    @(negedge clk);
    drive(p1, p2);
    conflict = has_op(p1) && has_op(p2);
    l1 = model_access(p1);
    l2 = model_access(p2);
    #1 check({tag, ".stall"}, DATA_W'(stall), DATA_W'(conflict));
    if (conflict) begin
      @(posedge clk); #1;
      push_zero_wb();
      compare_wb({tag, ".bubble"});
      check({tag, ".stall2"}, DATA_W'(stall), '0);
    end
    @(posedge clk); #1;
    push_wb(p1, l1);
    push_wb(p2, l2);
    compare_wb(tag);
  endtask

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic pipe_t rnd_pipe(input logic [ADDR_W-1:0] qidx);
    pipe_t p;
    int kind;
    kind = $urandom_range(0, 3);
    p.mr = kind[0];
    p.mw = kind[1];
    p.m2r = 1'($urandom_range(0, 1));
    p.rwe = 1'($urandom_range(0, 1));
    p.rc  = rnd128();
    p.rt  = REG_W'($urandom_range(0, 127));
    p.res = rnd128();
    if (p.mr || p.mw) p.res[ADDR_W+3:4] = qidx;
    return p;
  endfunction

  logic [ADDR_W-1:0] pool [16];
  logic [DATA_W-1:0] t_res;

  initial begin
    drive(nop(), nop());
    #12;
    push_zero_wb();
    compare_wb("reset");
    check("reset.stall", DATA_W'(stall), '0);
    @(negedge clk); reset = 1'b1;

    // Directed cases
    issue("st40", mk(1'b0, 1'b1, 128'h40, 128'h0123456789ABCDEF0123456789ABCDEF, 7'd1, 1'b0, 1'b0), nop());
    issue("ld40", nop(), mk(1'b1, 1'b0, 128'h40, '0, 7'd2, 1'b1, 1'b1));
    check("ld40.const", loadData_WB2, 128'h0123456789ABCDEF0123456789ABCDEF);

    issue("conf_st_ld", mk(1'b0, 1'b1, 128'h100, {32{4'hA}}, 7'd3, 1'b0, 1'b0),
          mk(1'b1, 1'b0, 128'h100, '0, 7'd4, 1'b1, 1'b1));
    check("conf_st_ld.const", loadData_WB2, {32{4'hA}});

    issue("pre200", mk(1'b0, 1'b1, 128'h200, {32{4'h1}}, 7'd0, 1'b0, 1'b0), nop());
    issue("pre210", nop(), mk(1'b0, 1'b1, 128'h210, {32{4'h2}}, 7'd0, 1'b0, 1'b0));
    issue("conf_ld_ld", mk(1'b1, 1'b0, 128'h200, '0, 7'd5, 1'b1, 1'b1),
          mk(1'b1, 1'b0, 128'h210, '0, 7'd6, 1'b1, 1'b1));
    check("conf_ld_ld.c1", loadData_WB1, {32{4'h1}});
    check("conf_ld_ld.c2", loadData_WB2, {32{4'h2}});

    issue("alu", mk(1'b0, 1'b0, 128'h5, '0, 7'd9, 1'b1, 1'b0), nop());
    check("alu.rt", DATA_W'(registerRT_WB1), DATA_W'(9));

    issue("st8000", mk(1'b0, 1'b1, 128'h8000, {32{4'h7}}, 7'd0, 1'b0, 1'b0), nop());
    issue("ld0", mk(1'b1, 1'b0, 128'h0, '0, 7'd7, 1'b1, 1'b1), nop());
    check("wrap.const", loadData_WB1, {32{4'h7}});
    issue("ld10f", mk(1'b1, 1'b0, 128'h10F, '0, 7'd8, 1'b1, 1'b1), nop());
    check("ld10f.const", loadData_WB1, {32{4'hA}});
    issue("both_flags", mk(1'b1, 1'b1, 128'h500, rnd128(), 7'd10, 1'b1, 1'b1), nop());

    // Reset during SECOND: pipe1 store lands, pipe2 is dropped.
    @(negedge clk);
    drive(mk(1'b0, 1'b1, 128'h300, {32{4'h3}}, 7'd11, 1'b1, 1'b0),
          mk(1'b0, 1'b1, 128'h300, {32{4'h9}}, 7'd12, 1'b1, 1'b0));
    t_res = model_access(mk(1'b0, 1'b1, 128'h300, {32{4'h3}}, 7'd11, 1'b1, 1'b0));
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    push_zero_wb();
    compare_wb("rst_second");
    check("rst_second.stall", DATA_W'(stall), '0);
    @(negedge clk); drive(nop(), nop());
    @(negedge clk); reset = 1'b1;
    issue("ld300", mk(1'b1, 1'b0, 128'h300, '0, 7'd13, 1'b1, 1'b1), nop());
    check("ld300.const", loadData_WB1, {32{4'h3}});

    // Random traffic over a small pre-filled address pool
    for (int k = 0; k < 16; k++) begin
      pool[k] = ADDR_W'((k * 131 + 17) % LS_DEPTH);
      t_res = rnd128();
      t_res[ADDR_W+3:4] = pool[k];
      issue("fill", mk(1'b0, 1'b1, t_res, rnd128(), 7'd0, 1'b0, 1'b0), nop());
    end
    for (int n = 0; n < 200; n++) begin
      issue($sformatf("rnd%0d", n), rnd_pipe(pool[$urandom_range(0, 15)]),
            rnd_pipe(pool[$urandom_range(0, 15)]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ls.md
Name: mem_stage_ls

Overview:
MEM-stage consumer of the dual-issue EX/MEM pipeline register. It takes both pipes' memory control, address (result) and store data, and performs loads and stores against a single-ported 128-bit local store. It serializes same-cycle memory requests from both pipes and stalls upstream while it does so. It registers everything needed by writeback into MEM/WB outputs.

Parameters:
DATA_W, 128, quadword width of result, store data and load data
REG_W, 7, register specifier width
LS_DEPTH, 2048, local store depth in quadwords (32 KB)
ADDR_W, 11, quadword index width, equal to log2(LS_DEPTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
memToReg_MEM1 / memToReg_MEM2  in  1  per pipe: writeback selects load data
regWriteEnable_MEM1 / regWriteEnable_MEM2  in  1  per pipe: register write enable
memRead_MEM1 / memRead_MEM2  in  1  per pipe: load request
memWrite_MEM1 / memWrite_MEM2  in  1  per pipe: store request
result_MEM1 / result_MEM2  in  DATA_W  per pipe: ALU result; byte address for memory ops
readDataRC_MEM1 / readDataRC_MEM2  in  DATA_W  per pipe: store data
registerRT_MEM1 / registerRT_MEM2  in  REG_W  per pipe: destination register
stall  out  1  upstream EX/MEM and earlier stages hold this cycle (combinational)
memToReg_WB1 / memToReg_WB2  out  1  registered memToReg
regWriteEnable_WB1 / regWriteEnable_WB2  out  1  registered write enable
result_WB1 / result_WB2  out  DATA_W  registered result
loadData_WB1 / loadData_WB2  out  DATA_W  registered load data
registerRT_WB1 / registerRT_WB2  out  REG_W  registered destination

Behaviour:
- Reset (reset=0, asynchronous): every WB output is 0, stall is 0, state is IDLE, and the pipe1 buffer is 0. Local store contents are not reset.
- Address: quadword index = result[ADDR_W+3:4]. Bits [3:0] are ignored. Higher bits are ignored, so addresses wrap modulo LS_DEPTH.
- Memory op per pipe: mem_op = memRead | memWrite. If both are set, the op is a store and loadData is 0.
- Non-load pipes: loadData_WB = 0.
- Single port: at most one access per clock edge.
- Conflict: mem_op on both pipes in the same cycle. Pipe1 is older and is always served first.
- FSM states: IDLE, SECOND.
- IDLE, no conflict:
  - At the edge, the (at most one) memory op is performed.
  - Both pipes' fields go to the WB outputs.
  - Load data is the read of the current array contents.
  - Latency: 1 cycle. stall = 0.
- IDLE with conflict:
  - stall = 1 this cycle.
  - At the edge, pipe1's access is performed and pipe1's WB fields plus load data are captured in an internal buffer.
  - WB outputs become a bubble: regWriteEnable_WB1/2 = 0, memToReg_WB1/2 = 0, other WB fields 0.
  - Next state: SECOND.
- SECOND:
  - Inputs are unchanged because upstream held them. stall = 0.
  - At the edge, pipe2's access is performed.
  - WB1 outputs come from the buffer; WB2 outputs come from the live inputs plus the read data.
  - Next state: IDLE.
  - Total latency: 2 cycles, and both pipes appear together.
- Ordering: serialization makes a pipe2 load see a pipe1 store to the same quadword in the same bundle. A store followed by a load in the next bundle returns the stored data.
- Reset asserted during SECOND: the state returns to IDLE and the buffer is cleared. A pipe1 store already performed remains in the array, and pipe2 is not performed.
- Bundles with no memory ops pass straight through in 1 cycle.

Decomposition:
- Shared package spu_mem_pkg holds:
  - DATA_W, REG_W, LS_DEPTH, ADDR_W constants;
  - the ls_state_t enum {IDLE, SECOND};
  - a wb_bundle_t struct {memToReg, regWriteEnable, result, loadData, registerRT} used for the buffer and the WB registers.
- One sub-module, ls_sram: single-port LS_DEPTH x DATA_W array with write enable and an asynchronous read of the addressed quadword. Its read data is captured into the WB registers at the edge. It has no reset.

Test Plan:
- Store/load: store 0x0123...CDEF at byte addr 0x40 on pipe1, then a load of 0x40 on pipe2 in the next bundle -> loadData_WB2 = 0x0123...CDEF one cycle after the load. stall stays 0 throughout.
- Same-bundle conflict: pipe1 stores 0xAAAA...AAAA at 0x100 and pipe2 loads 0x100.
  - Cycle T: stall = 1.
  - T+1: WB bubble (regWriteEnable_WB1/2 = 0).
  - T+2: regWriteEnable_WB2 = 1 and loadData_WB2 = 0xAAAA...AAAA; WB1 shows pipe1's fields.
- Load/load conflict: pre-store 0x11..11 at 0x200 and 0x22..22 at 0x210, then both pipes load -> 1 stall cycle, then loadData_WB1 = 0x11..11 and loadData_WB2 = 0x22..22 in the same cycle.
- ALU-only bundle: result_MEM1 = 0x5, registerRT_MEM1 = 7'd9, regWriteEnable = 1, no mem op -> next cycle result_WB1 = 0x5, registerRT_WB1 = 9, loadData_WB1 = 0, stall = 0.
- Wrap: store 0x77..77 at byte address 0x8000, then load address 0x0 -> 0x77..77. A load at 0x10F returns the quadword stored at 0x100.
- Reset in SECOND: issue a conflict with pipe1 storing 0x33..33 at 0x300, and drive reset = 0 during the SECOND cycle:
  - immediately: all WB outputs 0 and stall = 0;
  - after release, a load of 0x300 returns 0x33..33.
